pc_gen_stage: RTL
=================

# pc_gen_stage

Pre-fetch stage that owns the architectural fetch PC and feeds `fetch_stage` through a valid/ready address handshake. It holds the current PC, advances it by 4 on each accepted address, and applies branch and exception redirects, honouring the MIPS branch-delay-slot rule. When an address past the delay slot has already been issued, it reports this so downstream stages can squash the wrong-path instruction.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC issued first after reset.
- `clk  in  1`: clock, rising edge.
- `resetn  in  1`: asynchronous, active-low reset.
- `valid_o  out  1`: `pc_o` is a valid fetch address.
- `pc_o  out  32`: address offered to fetch.
- `ready_i  in  1`: fetch accepts `pc_o` this cycle; a handshake occurs when `valid_o && ready_i`.
- `br_valid_i  in  1`: one-cycle pulse from decode, a taken branch or jump resolved.
- `br_ds_pc_i  in  32`: PC of that branch's delay slot (branch PC + 4).
- `br_target_i  in  32`: branch target.
- `exc_valid_i  in  1`: one-cycle pulse from writeback, an exception or ERET redirect.
- `exc_target_i  in  32`: exception vector or EPC.
- `drop_o  out  1`: one-cycle pulse; squash the instruction fetched at `br_ds_pc_i + 4`.
- `br_pend_o  out  1`: a branch redirect is waiting for its delay slot to issue.

## Operation
- Registers:
  - `pc_r`: drives `pc_o`.
  - `last_pc_r`: last handshaken address.
  - `tgt_r`: saved branch target.
  - State: `RUN` or `BR_PEND`.
- `valid_o`: 0 in reset; 1 from the first posedge after `resetn` rises; stays 1 afterwards.
- Priority of next-PC selection, highest first:
  1. Exception: `pc_r <= exc_target_i`; state `RUN`; any pending branch is cancelled; `drop_o` is 0. Exception-driven flush of fetch and decode is owned elsewhere.
  2. Branch accepted in `RUN`, with `ds = br_ds_pc_i`:
     - `pc_r == ds` and no handshake this cycle: `tgt_r <= br_target_i`; go to `BR_PEND`.
     - `pc_r == ds` and handshake this cycle: the delay slot issues now, so `pc_r <= br_target_i`; stay in `RUN`.
     - `pc_r == ds+4` and no handshake: `pc_r <= br_target_i`.
     - `pc_r == ds+4` and handshake: the wrong-path address issues; `pc_r <= br_target_i`; `drop_o` pulses the next cycle.
     - `pc_r == ds+8`, meaning `last_pc_r == ds+4` was already issued: `pc_r <= br_target_i`; `drop_o` pulses the next cycle.
     - Any other `pc_r`: illegal. Treat as `ds+4` without drop; a bench assertion flags it.
  3. `BR_PEND` with a handshake: `pc_r <= tgt_r`; go to `RUN`. `br_pend_o = (state == BR_PEND)`.
  4. Handshake otherwise: `pc_r <= pc_r + 4`, modulo 2^32. Wrap-around from `FFFF_FFFC` to 0 is not trapped.
- `br_valid_i` while in `BR_PEND`: ignored. A bench assertion flags it, since a branch in a delay slot is undefined.
- `pc_o` never changes while `valid_o && !ready_i` unless an exception or branch redirect arrives.

## Timing
- All outputs are registered. Redirect latency is 1 cycle: the new PC appears on `pc_o` the cycle after the pulse, or after the delay-slot handshake when in `BR_PEND`.
- `drop_o` is high exactly one cycle, the cycle after the triggering branch pulse.
- Reset (asynchronous, any time, including mid-`BR_PEND`):
  - `pc_r = RESET_PC`, `valid_o = 0`, state `RUN`, `drop_o = 0`.
  - `last_pc_r = RESET_PC - 4`, `tgt_r = 0`.
- Back-to-back handshakes sustain one address per cycle.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` and `EXC_VECTOR` constants.
  - A 1-bit state enum `pcg_state_t {RUN, BR_PEND}`.
  - A `pc_t` 32-bit typedef.
- No sub-module is needed. The next-PC mux stays inline, about 150 lines.

## Test plan
- Reset release, `ready_i = 1` constant:
  - `pc_o` sequence: BFC00000, BFC00004, BFC00008 on consecutive cycles.
  - `valid_o` is 0 before the first edge after release.
- Hold `ready_i = 0` for 3 cycles at 0x100:
  - `pc_o` stays 0x100.
  - After release, the next handshakes are 0x100, then 0x104.
- Branch with `ds = 0x204`, target 0x400:
  - Case `pc_r = 0x204`, `ready_i = 0`: `br_pend_o = 1`; on the next handshake, issue 0x204, then 0x400.
  - Case `pc_r = 0x208`, handshake this cycle: 0x208 is issued, `drop_o` pulses once, then 0x400.
- `exc_valid_i` and `br_valid_i` in the same cycle, `exc_target_i = 0xBFC00380`: `pc_o = BFC00380`, `drop_o = 0`, `br_pend_o = 0`.
- Exception during `BR_PEND`: the pending target is discarded; the sequence continues from the exception vector.
- Assert `resetn = 0` mid-`BR_PEND`, between clock edges:
  - `valid_o` drops immediately, `pc_o = BFC00000`.
  - After release, fetch restarts cleanly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception vectors, PC type and the
// pre-fetch stage state encoding.
package cpu_pkg;

    typedef logic [31:0] pc_t;

    localparam pc_t RESET_PC   = 32'hBFC0_0000;
    localparam pc_t EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic {
        RUN     = 1'b0,
        BR_PEND = 1'b1
    } pcg_state_t;

endpackage

// File: rtl/pc_gen_stage_if.sv
// Fetch-address handshake plus redirect inputs and squash/pending outputs
// of the PC generator. master = pc_gen_stage side.
interface pc_gen_stage_if;
    import cpu_pkg::*;

    logic valid_o;
    pc_t  pc_o;
    logic ready_i;
    logic br_valid_i;
    pc_t  br_ds_pc_i;
    pc_t  br_target_i;
    logic exc_valid_i;
    pc_t  exc_target_i;
    logic drop_o;
    logic br_pend_o;

    modport master (
        output valid_o,
        output pc_o,
        output drop_o,
        output br_pend_o,
        input  ready_i,
        input  br_valid_i,
        input  br_ds_pc_i,
        input  br_target_i,
        input  exc_valid_i,
        input  exc_target_i
    );

    modport slave (
        input  valid_o,
        input  pc_o,
        input  drop_o,
        input  br_pend_o,
        output ready_i,
        output br_valid_i,
        output br_ds_pc_i,
        output br_target_i,
        output exc_valid_i,
        output exc_target_i
    );

endinterface

// File: rtl/pc_gen_stage.sv
// Pre-fetch stage: owns the fetch PC, offers it over valid/ready and applies
// branch (with MIPS delay slot) and exception redirects.
module pc_gen_stage #(
    parameter cpu_pkg::pc_t RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  resetn,
    pc_gen_stage_if.master        bus
);
    import cpu_pkg::*;

    pcg_state_t state_q, state_d;
    pc_t        pc_q, pc_d;
    pc_t        last_pc_q, last_pc_d;
    pc_t        tgt_q, tgt_d;
    logic       valid_q, valid_d;
    logic       drop_q, drop_d;

    logic       hs;
    pc_t        ds;

    assign hs = valid_q && bus.ready_i;
    assign ds = bus.br_ds_pc_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            last_pc_q <= RESET_PC - 32'd4;
            tgt_q     <= '0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
            tgt_q     <= tgt_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_pc_d = hs ? pc_q : last_pc_q;
        tgt_d     = tgt_q;
        valid_d   = 1'b1;
        drop_d    = 1'b0;

        if (bus.exc_valid_i) begin
            pc_d    = bus.exc_target_i;
            state_d = RUN;
        end else if (bus.br_valid_i && state_q == RUN) begin
            if (pc_q == ds) begin
                // Delay slot not yet issued: park the target until it goes out.
                if (hs) begin
                    pc_d = bus.br_target_i;
                end else begin
                    tgt_d   = bus.br_target_i;
                    state_d = BR_PEND;
                end
            end else if (pc_q == ds + 32'd4) begin
                pc_d   = bus.br_target_i;
                drop_d = hs;
            end else if (pc_q == ds + 32'd8 && last_pc_q == ds + 32'd4) begin
                pc_d   = bus.br_target_i;
                drop_d = 1'b1;
            end else begin
                pc_d = bus.br_target_i;
            end
        end else if (state_q == BR_PEND) begin
            if (hs) begin
                pc_d    = tgt_q;
                state_d = RUN;
            end
        end else if (hs) begin
            pc_d = pc_q + 32'd4;
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.pc_o      = pc_q;
    assign bus.drop_o    = drop_q;
    assign bus.br_pend_o = (state_q == BR_PEND);

endmodule
